// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO, with busy/done handshake and MTHI/MTLO writes.
// Optional macro MDU_FAST_MULT_EN: MULT/MULTU use one combinational multiplier and skip the iterative phase.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sign_a, sign_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [DW-1:0]    prod, prod_fix;
    logic [WIDTH-1:0] quo, rem;

    // Signed ops work on magnitudes; signs are reapplied in FIX.
    assign sign_a = ~op[0] & srcA[WIDTH-1];
    assign sign_b = ~op[0] & srcB[WIDTH-1];
    assign abs_a  = sign_a ? (-srcA) : srcA;
    assign abs_b  = sign_b ? (-srcB) : srcB;

    // Multiply: acc = {partial product, remaining multiplier}; divide: acc = {partial remainder, dividend/quotient}.
    assign add_sum  = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign sub_diff = acc_q[DW-1:WIDTH-1] - {1'b0, b_q};

`ifdef MDU_FAST_MULT_EN
    assign prod = is_div_q ? acc_q : (DW'(a_q) * DW'(b_q));
`else
    assign prod = acc_q;
`endif
    assign prod_fix = neg_res_q ? (-prod) : prod;
    assign quo      = acc_q[WIDTH-1:0];
    assign rem      = acc_q[DW-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wd;
                if (lo_we) lo_d = wd;
                if (start) begin
                    is_div_d  = op[1];
                    a_d       = abs_a;
                    b_d       = abs_b;
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    acc_d     = {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                    cnt_d     = '0;
                    state_d   = S_CALC;
`ifdef MDU_FAST_MULT_EN
                    if (!op[1]) state_d = S_FIX;
`endif
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    if (sub_diff[WIDTH]) acc_d = {acc_q[DW-2:0], 1'b0};
                    else                 acc_d = {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {add_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    // Divide by zero: all-ones quotient, dividend passed through as remainder.
                    if (b_q == '0) begin
                        lo_d = '1;
                        hi_d = neg_rem_q ? (-a_q) : a_q;
                    end else begin
                        lo_d = neg_res_q ? (-quo) : quo;
                        hi_d = neg_rem_q ? (-rem) : rem;
                    end
                end else begin
                    hi_d = prod_fix[DW-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
